// File: rtl/md_if.sv
// Operand/control and HI/LO bundle between the EX stage
// and the multiply/divide unit.
interface md_if;
  logic        start;
  logic [2:0]  mdctr;
  logic        we;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdctr, we, A, B,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdctr, we, A, B,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO pair.
// Result lands on HI/LO at the edge busy drops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave md
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  logic          busy_q;
  logic [CW-1:0] cnt;
  op_e           op;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          go;
  logic          mt_hi;
  logic          mt_lo;
  logic          sgn;
  logic [31:0]   da;
  logic [31:0]   db;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [63:0]   res;
  logic          wr_ok;

  assign go    = md.start && !md.mdctr[2];
  assign mt_hi = md.we && (md.mdctr == 3'd4);
  assign mt_lo = md.we && (md.mdctr == 3'd5);

  // Result of the latched op; signed divide runs on magnitudes
  always_comb begin
    sgn   = (op == OP_DIV);
    da    = (sgn && a_q[31]) ? -a_q : a_q;
    db    = (sgn && b_q[31]) ? -b_q : b_q;
    uq    = (db == '0) ? '0 : da / db;
    ur    = (db == '0) ? '0 : da % db;
    res   = '0;
    wr_ok = 1'b1;
    unique case (op)
      OP_MULT:
        res = $signed({{32{a_q[31]}}, a_q})
            * $signed({{32{b_q[31]}}, b_q});
      OP_MULTU:
        res = {32'd0, a_q} * {32'd0, b_q};
      OP_DIV: begin
        res[31:0]  = (a_q[31] ^ b_q[31]) ? -uq : uq;
        res[63:32] = a_q[31] ? -ur : ur;
        wr_ok      = (b_q != '0);
      end
      OP_DIVU: begin
        res   = {ur, uq};
        wr_ok = (b_q != '0);
      end
      default: res = '0;
    endcase
  end

  // Launch, countdown, completion write and mthi/mtlo
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      op     <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (busy_q) begin
      cnt <= cnt - ONE;
      if (cnt == ONE) begin
        busy_q <= 1'b0;
        if (wr_ok) begin
          hi_q <= res[63:32];
          lo_q <= res[31:0];
        end
      end
    end else if (go) begin
      busy_q <= 1'b1;
      op     <= op_e'(md.mdctr[1:0]);
      a_q    <= md.A;
      b_q    <= md.B;
      cnt    <= md.mdctr[1] ? DC : MC;
    end else if (mt_hi) begin
      hi_q <= md.A;
    end else if (mt_lo) begin
      lo_q <= md.A;
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: random and directed
// mult/div/mthi/mtlo traffic against a plain-arithmetic model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  md_if mif();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .md(mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mh = '0;
  logic [31:0] ml = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(
    int op, logic [31:0] a, logic [31:0] b,
    logic [31:0] h, logic [31:0] l);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          q;
    longint          r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: return 64'(sa * sb);
      1: return ua * ub;
      2: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (mif.busy && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 60) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b", mif.busy);
    end
  endtask

  task automatic issue(int op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    exp_t e;
    wait_idle();
    mif.start = 1'b1;
    mif.mdctr = 3'(op);
    mif.we    = 1'($urandom_range(1));
    mif.A     = a;
    mif.B     = b;
    @(posedge clk); #1;
    mif.start = 1'b0;
    mif.we    = 1'b0;
    mif.A     = $urandom;
    mif.B     = $urandom;
    r    = ref_res(op, a, b, mh, ml);
    e.n  = (op >= 2) ? DC : MC;
    e.hi = r[63:32];
    e.lo = r[31:0];
    sbq.push_back(e);
    mh = e.hi;
    ml = e.lo;
  endtask

  task automatic mt(bit to_lo, logic [31:0] d);
    wait_idle();
    mif.we    = 1'b1;
    mif.mdctr = to_lo ? 3'd5 : 3'd4;
    mif.A     = d;
    @(posedge clk); #1;
    mif.we = 1'b0;
    if (to_lo) ml = d;
    else mh = d;
    chk("mt_busy", 32'(mif.busy), 32'd0);
    chk("mt_hi", mif.hi, mh);
    chk("mt_lo", mif.lo, ml);
  endtask

  // Monitor: busy length, HI/LO stability and result on completion
  int          bcnt = 0;
  logic        pbusy = 1'b0;
  logic [31:0] sh;
  logic [31:0] sl;
  always @(negedge clk) begin
    if (!reset) begin
      pbusy = 1'b0;
      bcnt  = 0;
    end else begin
      if (mif.busy) begin
        if (!pbusy) begin
          sh   = mif.hi;
          sl   = mif.lo;
          bcnt = 0;
        end
        bcnt++;
        chk("hold_hi", mif.hi, sh);
        chk("hold_lo", mif.lo, sl);
      end else if (pbusy) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: no pending op");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("busy_len", 32'(bcnt), 32'(e.n));
          chk("res_hi", mif.hi, e.hi);
          chk("res_lo", mif.lo, e.lo);
        end
      end
      pbusy = mif.busy;
    end
  end

  initial begin
    mif.start = 1'b0;
    mif.mdctr = 3'd0;
    mif.we    = 1'b0;
    mif.A     = '0;
    mif.B     = '0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(mif.busy), 32'd0);
    chk("rst_hi", mif.hi, 32'd0);
    chk("rst_lo", mif.lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    issue(1, 32'hFFFF_FFFF, 32'd2);
    issue(0, 32'hFFFF_FFFD, 32'd7);
    issue(2, 32'hFFFF_FFF9, 32'd2);
    issue(3, 32'hFFFF_FFF9, 32'd2);
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
    mt(1'b0, 32'h1111_1111);
    mt(1'b1, 32'h2222_2222);
    issue(2, 32'h1234_5678, 32'd0);
    wait_idle();
    chk("dz_hi", mif.hi, 32'h1111_1111);
    chk("dz_lo", mif.lo, 32'h2222_2222);

    // Requests during busy must be ignored
    issue(1, 32'hDEAD_BEEF, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      mif.start = 1'b1;
      mif.mdctr = (i == 1) ? 3'd4 : 3'd2;
      mif.we    = 1'b1;
      mif.A     = $urandom;
      mif.B     = $urandom;
      @(posedge clk); #1;
    end
    mif.start = 1'b0;
    mif.we    = 1'b0;

    // Invalid start/we codes in an idle cycle
    wait_idle();
    mif.start = 1'b1;
    mif.mdctr = 3'd6;
    mif.we    = 1'b1;
    mif.A     = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mif.start = 1'b0;
    mif.we    = 1'b0;
    chk("inv_busy", 32'(mif.busy), 32'd0);
    chk("inv_hi", mif.hi, mh);
    chk("inv_lo", mif.lo, ml);

    // Random traffic, back-to-back
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [31:0] a;
      logic [31:0] b;
      sel = $urandom_range(5);
      a = $urandom;
      b = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) b = 32'($urandom_range(9));
      if (sel < 4) issue(sel, a, b);
      else mt(sel == 5, a);
    end

    // Asynchronous abort mid-divide
    issue(2, 32'h7654_3210, 32'd3);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(mif.busy), 32'd0);
    chk("abort_hi", mif.hi, 32'd0);
    chk("abort_lo", mif.lo, 32'd0);
    sbq.delete();
    mh = '0;
    ml = '0;
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("post_busy", 32'(mif.busy), 32'd0);
      chk("post_hi", mif.hi, 32'd0);
      chk("post_lo", mif.lo, 32'd0);
    end

    issue(1, 32'd3, 32'd4);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
